// File: rtl/fp_pkg.sv
// fp_pkg: shared FP32 field widths, operand struct, alignment FSM states
// and helpers that derive effective exponent / extended mantissa.
package fp_pkg;
   localparam int FP_EXP_W = 8;
   localparam int FP_FRAC_W = 23;
   localparam int FP_ALIGN_W = 27;
   typedef struct packed {
      logic sign;
      logic [FP_EXP_W-1:0] exp;
      logic [FP_FRAC_W-1:0] frac;
   } fp32_t;
   typedef enum logic [1:0] {IDLE, CMP, SHIFT, DONE} align_state_t;
   // Denormals behave as exponent 1 with a zero hidden bit.
   function automatic logic [FP_EXP_W-1:0] eff_exp(input fp32_t x);
      return (x.exp == '0) ? FP_EXP_W'(1) : x.exp;
   endfunction
   function automatic logic [FP_ALIGN_W-1:0] align_man(input fp32_t x);
      return {x.exp != '0, x.frac, 3'b000};
   endfunction
endpackage

// File: rtl/sticky_rshift.sv
// sticky_rshift: right shift by 0..MAX_SH, ORing every bit shifted out
// (and the old bit0) into the new bit0.
module sticky_rshift #(
   parameter int W = 27,
   parameter int MAX_SH = 4,
   parameter int SW = $clog2(MAX_SH + 1)
) (
   input  logic [W-1:0]  din,
   input  logic [SW-1:0] amt,
   output logic [W-1:0]  dout
);
   logic [W-1:0] mask;
   always_comb begin
      mask = (W'(1) << amt) - W'(1);
      dout = din >> amt;
      dout[0] = dout[0] | (|(din & mask));
   end
endmodule

// File: rtl/fp_align_seq.sv
// fp_align_seq: FP32 adder front end; picks the larger-exponent operand and
// aligns the smaller mantissa SHIFT_PER_CYC bits per cycle with sticky.
module fp_align_seq
   import fp_pkg::*;
#(
   parameter int SHIFT_PER_CYC = 4,
   parameter int ALIGN_W = FP_ALIGN_W
) (
   input  logic                CLK,
   input  logic                nRST,
   input  logic                flush,
   input  logic                in_valid,
   output logic                in_ready,
   input  logic [31:0]         op_a,
   input  logic [31:0]         op_b,
   output logic                out_valid,
   input  logic                out_ready,
   output logic [FP_EXP_W-1:0] big_exp,
   output logic [ALIGN_W-1:0]  big_man,
   output logic [ALIGN_W-1:0]  small_man,
   output logic                big_sign,
   output logic                small_sign,
   output logic                swapped
);
   localparam int SW = $clog2(SHIFT_PER_CYC + 1);
   align_state_t state, state_nx;
   fp32_t a_q, b_q;
   logic [FP_EXP_W-1:0] ea, eb, mag, rem;
   logic [FP_EXP_W:0] diff;
   logic [ALIGN_W-1:0] sm_sel, shifted;
   logic [SW-1:0] k;

   assign ea = eff_exp(a_q);
   assign eb = eff_exp(b_q);
   assign diff = {1'b0, ea} - {1'b0, eb};
   assign mag = diff[FP_EXP_W] ? eb - ea : ea - eb;
   assign sm_sel = diff[FP_EXP_W] ? align_man(a_q) : align_man(b_q);
   assign k = (rem < FP_EXP_W'(SHIFT_PER_CYC)) ? SW'(rem) : SW'(SHIFT_PER_CYC);
   assign in_ready = (state == IDLE);
   assign out_valid = (state == DONE);

   sticky_rshift #(.W(ALIGN_W), .MAX_SH(SHIFT_PER_CYC)) u_shift (
      .din(small_man),
      .amt(k),
      .dout(shifted)
   );

   always_ff @(posedge CLK or negedge nRST)
      if (!nRST) state <= IDLE;
      else state <= state_nx;

   always_comb begin
      state_nx = state;
      case (state)
         IDLE: state_nx = in_valid ? CMP : IDLE;
         CMP: state_nx = (mag == '0 || mag >= FP_EXP_W'(ALIGN_W)) ? DONE : SHIFT;
         SHIFT: state_nx = (rem <= FP_EXP_W'(SHIFT_PER_CYC)) ? DONE : SHIFT;
         DONE: state_nx = out_ready ? IDLE : DONE;
         default: state_nx = IDLE;
      endcase
      if (flush) state_nx = IDLE;
   end

   // Data registers need no flush gating: after a flush they are don't-care.
   always_ff @(posedge CLK or negedge nRST) begin
      if (!nRST) begin
         a_q <= '0;
         b_q <= '0;
         rem <= '0;
         big_exp <= '0;
         big_man <= '0;
         small_man <= '0;
         big_sign <= 1'b0;
         small_sign <= 1'b0;
         swapped <= 1'b0;
      end else begin
         if (in_ready && in_valid) begin
            a_q <= op_a;
            b_q <= op_b;
         end
         if (state == CMP) begin
            swapped <= diff[FP_EXP_W];
            big_exp <= diff[FP_EXP_W] ? eb : ea;
            big_man <= diff[FP_EXP_W] ? align_man(b_q) : align_man(a_q);
            big_sign <= diff[FP_EXP_W] ? b_q.sign : a_q.sign;
            small_sign <= diff[FP_EXP_W] ? a_q.sign : b_q.sign;
            small_man <= (mag >= FP_EXP_W'(ALIGN_W)) ? ALIGN_W'(|sm_sel) : sm_sel;
            rem <= mag;
         end
         if (state == SHIFT) begin
            small_man <= shifted;
            rem <= rem - FP_EXP_W'(k);
         end
      end
   end
endmodule

// File: doc/fp_align_seq.md
Name: fp_align_seq

Overview:
- Multi-cycle alignment sequencer for the FP32 adder front end.
- Accepts two IEEE-754 single operands over a valid/ready handshake and decides which operand has the larger exponent.
- Shifts the smaller mantissa right by the exponent difference, SHIFT_PER_CYC bits per cycle, with sticky collection.
- Presents aligned mantissas to the add/normalise stage over a second valid/ready handshake.

Parameters:
- SHIFT_PER_CYC, 4, right-shift bits applied per SHIFT cycle. Legal values: 1, 2, 4, 8.
- ALIGN_W, 27, aligned mantissa width: hidden bit + 23 fraction + guard/round/sticky. Fixed for FP32; do not override.

Ports:
- CLK  input  1  system clock
- nRST  input  1  asynchronous active-low reset
- flush  input  1  synchronous abort of the in-flight operation
- in_valid  input  1  operand pair valid
- in_ready  output  1  block can accept an operand pair
- op_a  input  32  FP32 operand A
- op_b  input  32  FP32 operand B
- out_valid  output  1  aligned result valid
- out_ready  input  1  downstream accepts result
- big_exp  output  8  larger effective exponent
- big_man  output  27  larger operand mantissa, {hidden, frac, 3'b000}
- small_man  output  27  aligned smaller mantissa; bit0 = sticky
- big_sign  output  1  sign of the larger-exponent operand
- small_sign  output  1  sign of the smaller-exponent operand
- swapped  output  1  1 when op_b supplied big_*

Behaviour:
- Clock and reset: one clock (CLK); reset nRST is asynchronous, active-low.
- Reset values: state=IDLE, out_valid=0, all data outputs=0, swapped=0. in_ready=1 while in IDLE, including during reset.
- in_ready is combinational: (state==IDLE).
- Input handshake: in_valid & in_ready at edge T. Operands are registered; state becomes CMP at T+1.
- Effective exponent: exp field, except exp==0 gives 1 with hidden bit 0. Hidden bit = (exp!=0). NaN/Inf are not special-cased here; the downstream stage handles them.
- CMP state, one cycle:
  - 9-bit diff = {0,ea}-{0,eb}; borrow (bit8) set means eb>ea, so swapped=1.
  - Register the magnitude |diff| (8 bits) as the remaining shift count.
  - Equal exponents: swapped=0.
  - big_*/small_* are loaded from the selected operands in this cycle.
- CMP transitions:
  - |diff|==0 goes to DONE.
  - |diff|>=27 goes to DONE; small_man = 27'd1 if the small mantissa is nonzero, else 0 (clamp).
  - Otherwise goes to SHIFT.
- SHIFT state:
  - Each cycle, shift small_man right by k = min(remaining, SHIFT_PER_CYC).
  - OR all shifted-out bits and the old bit0 into the new bit0 (sticky); remaining -= k.
  - When remaining reaches 0 after the shift, go to DONE.
- Latency: out_valid rises at T+2+ceil(|diff|/SHIFT_PER_CYC) for |diff|<27; at T+2 for the clamp case.
- DONE state:
  - out_valid=1 and all outputs stable until out_valid & out_ready, then IDLE.
  - No new input is accepted in the same cycle as the output handshake; in_ready rises the cycle after.
- flush: from any state, next state=IDLE and out_valid=0. Data outputs hold their values (don't-care). flush has priority over both handshakes in the same cycle.
- Reset asserted mid-operation: immediate return to reset values; the operation is lost.
- Outputs are registered; no combinational path from in_* to out_*.

Decomposition:
- Shared package fp_pkg holds:
  - localparams FP_EXP_W=8, FP_FRAC_W=23, FP_ALIGN_W=27
  - typedef fp32_t (sign/exp/frac struct)
  - enum align_state_t {IDLE, CMP, SHIFT, DONE}
- One natural sub-module, sticky_rshift: combinational right shift by 0..SHIFT_PER_CYC with sticky OR, instantiated once in the SHIFT datapath.
- Exponent difference/magnitude stays inline.

Test Plan:
1. op_a=0x3F800000, op_b=0x3F800000 -> out_valid at T+2; big_exp=0x7F, big_man=small_man=0x4000000, swapped=0.
2. op_a=0x3F800000, op_b=0x3E800000 (diff 2) -> out_valid at T+3; small_man=0x1000000, sticky 0, swapped=0.
3. op_a=0x3F000000, op_b=0x40400000 -> swapped=1, big_exp=0x80, big_man=0x6000000, small_man=0x1000000, out_valid at T+3.
4. op_a=0x44800000, op_b=0x3F800001 (diff 10) -> 3 SHIFT cycles, out_valid at T+5; small_man=0x0010001 (sticky set).
5. op_a=0x3F800000, op_b=0x30800000 (diff 30) -> clamp; out_valid at T+2, small_man=0x0000001.
6. Case 4 with out_ready low for 5 cycles -> outputs held stable, in_ready=0. Then pulse flush during SHIFT of a new operation -> IDLE next cycle, out_valid never asserted, in_ready=1.
